// File: rtl/lc3_decode_pkg.sv
// +----------------------------------------------------------------------------+
// | lc3_decode_pkg: opcodes, control-field enums and the LC3 decode function  |
// | Optional macro: LC3_DECODE_ILLEGAL_FLAG_EN adds the per-entry illegal bit. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package lc3_decode_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_AND = 2'd1, ALU_NOT = 2'd2} alu_e;
  typedef enum logic [1:0] {PC1_NONE = 2'd0, PC1_OFF9 = 2'd1, PC1_OFF6 = 2'd2, PC1_BASE = 2'd3} pcsel1_e;
  typedef enum logic [1:0] {WSEL_ALU = 2'd0, WSEL_PC = 2'd1, WSEL_MEM = 2'd2} wsel_e;

  typedef struct packed {
    alu_e    alu;
    pcsel1_e pcsel1;
    logic    pcsel2;
    logic    op2sel;
  } ectrl_t;

  typedef struct packed {
    ectrl_t e;
    wsel_e  w;
    logic   mem;
`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
    logic   illegal;
`endif
  } dec_ctrl_t;

  function automatic dec_ctrl_t decode_ir(input logic [15:0] ir);
    dec_ctrl_t d;
    logic      unused_ir;
    unused_ir = ^{ir[11:6], ir[4:0]};
    d = '0;
    case (ir[15:12])
      OP_ADD: begin d.e.alu = ALU_ADD; d.e.op2sel = ~ir[5]; end
      OP_AND: begin d.e.alu = ALU_AND; d.e.op2sel = ~ir[5]; end
      OP_NOT: d.e.alu = ALU_NOT;
      OP_BR, OP_ST, OP_STI: begin d.e.pcsel1 = PC1_OFF9; d.e.pcsel2 = 1'b1; end
      OP_JMP: d.e.pcsel1 = PC1_BASE;
      OP_LD, OP_LDI: begin d.e.pcsel1 = PC1_OFF9; d.e.pcsel2 = 1'b1; d.w = WSEL_MEM; end
      OP_LDR: begin d.e.pcsel1 = PC1_OFF6; d.w = WSEL_MEM; end
      OP_LEA: begin d.e.pcsel1 = PC1_OFF9; d.e.pcsel2 = 1'b1; d.w = WSEL_PC; end
      OP_STR: d.e.pcsel1 = PC1_OFF6;
`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
      default: d.illegal = 1'b1;
`else
      default: ;
`endif
    endcase
    // Only the indirect forms need the second memory access.
    d.mem = (ir[15:12] == OP_LDI) || (ir[15:12] == OP_STI);
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_decode_fifo.sv
// +----------------------------------------------------------------------------+
// | lc3_decode_fifo: DEPTH-entry synchronous FIFO of an arbitrary entry type,  |
// | with synchronous active-low reset and synchronous flush.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lc3_decode_fifo #(
  parameter int  DEPTH   = 2,
  parameter type T_ENTRY = logic [7:0],
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  T_ENTRY           din,
  input  logic             pop,
  output T_ENTRY           dout,
  output logic [CNT_W-1:0] count
);

  T_ENTRY           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push = push && (r_count < CNT_W'(DEPTH));
  assign w_pop  = pop && (r_count != '0);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Flush shares the reset path: a coincident pop is consumed simply because
  // everything it left behind is discarded too.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/lc3_decode_pipe.sv
// +----------------------------------------------------------------------------+
// | lc3_decode_pipe: LC3 decode stage with a DEPTH-entry output buffer.       |
// | Optional macro: LC3_DECODE_ILLEGAL_FLAG_EN adds output port illegal_op.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lc3_decode_pipe
  import lc3_decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 2,
  parameter int E_CTRL_W = 6,
  parameter int W_CTRL_W = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   IR_in,
  input  logic [DATA_W-1:0]   npc_in,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   IR,
  output logic [DATA_W-1:0]   npc_out,
  output logic [E_CTRL_W-1:0] E_control,
  output logic [W_CTRL_W-1:0] W_control,
  output logic                Mem_control
`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
  ,
  output logic                illegal_op
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] npc;
    dec_ctrl_t         ctrl;
  } entry_t;

  entry_t           w_in_entry;
  entry_t           w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_in_entry      = '0;
    w_in_entry.ir   = IR_in;
    w_in_entry.npc  = npc_in;
    w_in_entry.ctrl = decode_ir(IR_in[15:0]);
  end

  assign in_ready  = reset && (w_count < CNT_W'(DEPTH));
  assign out_valid = (w_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  lc3_decode_fifo #(
    .DEPTH   (DEPTH),
    .T_ENTRY (entry_t)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (w_push),
    .din   (w_in_entry),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count)
  );

  // Storage is not reset, so every head field is masked while the buffer is empty.
  assign IR          = out_valid ? w_head.ir       : '0;
  assign npc_out     = out_valid ? w_head.npc      : '0;
  assign E_control   = out_valid ? w_head.ctrl.e   : '0;
  assign W_control   = out_valid ? w_head.ctrl.w   : '0;
  assign Mem_control = out_valid ? w_head.ctrl.mem : 1'b0;
`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
  assign illegal_op  = out_valid ? w_head.ctrl.illegal : 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lc3_decode_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_lc3_decode_pipe: scoreboard bench for lc3_decode_pipe.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lc3_decode_pipe;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] IR_in = '0;
  logic [15:0] npc_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_control;
  logic [1:0]  W_control;
  logic        Mem_control;
`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
  logic        illegal_op;
`endif

  lc3_decode_pipe #(.DATA_W(16), .DEPTH(DEPTH), .E_CTRL_W(6), .W_CTRL_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .IR_in       (IR_in),
    .npc_in      (npc_in),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .IR          (IR),
    .npc_out     (npc_out),
    .E_control   (E_control),
    .W_control   (W_control),
    .Mem_control (Mem_control)
`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
    ,
    .illegal_op  (illegal_op)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        mem;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t head;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   popped = 1'b0;

  // Decode table written straight from the opcode list as field numbers.
  function automatic exp_t ref_entry(input logic [15:0] ir, input logic [15:0] npc);
    exp_t x;
    int alu, pc1, pc2, op2, w, mem, ill;
    alu = 0; pc1 = 0; pc2 = 0; op2 = 0; w = 0; mem = 0; ill = 0;
    case (ir[15:12])
      4'h1: op2 = ir[5] ? 0 : 1;
      4'h5: begin alu = 1; op2 = ir[5] ? 0 : 1; end
      4'h9: alu = 2;
      4'h0, 4'h3: begin pc1 = 1; pc2 = 1; end
      4'hB: begin pc1 = 1; pc2 = 1; mem = 1; end
      4'hC: pc1 = 3;
      4'h2: begin pc1 = 1; pc2 = 1; w = 2; end
      4'hA: begin pc1 = 1; pc2 = 1; w = 2; mem = 1; end
      4'h6: begin pc1 = 2; w = 2; end
      4'hE: begin pc1 = 1; pc2 = 1; w = 1; end
      4'h7: pc1 = 2;
      default: ill = 1;
    endcase
    x.ir  = ir;
    x.npc = npc;
    x.e   = 6'(alu * 16 + pc1 * 4 + pc2 * 2 + op2);
    x.w   = 2'(w);
    x.mem = 1'(mem);
    x.ill = 1'(ill);
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented head and handshake flags, retires popped entries.
  initial forever begin
    @(negedge clock);
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(reset && (q.size() < DEPTH)));
    if (q.size() != 0) begin
      head = q[0];
      check("IR", 64'(IR), 64'(head.ir));
      check("npc_out", 64'(npc_out), 64'(head.npc));
      check("E_control", 64'(E_control), 64'(head.e));
      check("W_control", 64'(W_control), 64'(head.w));
      check("Mem_control", 64'(Mem_control), 64'(head.mem));
`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
      check("illegal_op", 64'(illegal_op), 64'(head.ill));
`endif
    end else begin
      check("gated_outputs", 64'({IR, npc_out, E_control, W_control, Mem_control}), 64'd0);
`ifdef LC3_DECODE_ILLEGAL_FLAG_EN
      check("gated_illegal", 64'(illegal_op), 64'd0);
`endif
    end
    if (out_valid && out_ready && reset && q.size() != 0) begin
      void'(q.pop_front());
      popped = 1'b1;
    end
  end

  // Model: predicts what the coming edge accepts, flushes or resets.
  initial forever begin
    @(negedge clock);
    #1;
    if (!reset) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else if (in_valid && ((q.size() + (popped ? 1 : 0)) < DEPTH)) begin
      q.push_back(ref_entry(IR_in, npc_in));
    end
    popped = 1'b0;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [15:0] ir, input logic [15:0] npc);
    int t = 0;
    in_valid = 1'b1;
    IR_in    = ir;
    npc_in   = npc;
    @(negedge clock);
    while (!in_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %0b for IR %0h, required 1", in_ready, ir);
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int t;
    reset = 1'b0; in_valid = 1'b1; IR_in = 16'h1234; npc_in = 16'h0001;
    repeat (2) tick();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    send(16'h12A3, 16'h3001);
    send(16'h5705, 16'h3002);
    send(16'hA000, 16'h3003);
    send(16'h6000, 16'h3004);
    repeat (3) tick();

    out_ready = 1'b0;
    fork
      begin
        send(16'h1021, 16'h4000);
        send(16'h9FFF, 16'h4001);
        send(16'hC1C0, 16'h4002);
      end
      begin
        repeat (6) tick();
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();

    out_ready = 1'b0;
    send(16'h0E05, 16'h5000);
    send(16'h2001, 16'h5001);
    in_valid = 1'b1; IR_in = 16'hE010; npc_in = 16'h5002; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    send(16'h7040, 16'h5003);
    repeat (3) tick();

    out_ready = 1'b0;
    send(16'h3001, 16'h6000);
    send(16'hB002, 16'h6001);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    out_ready = 1'b1;
    send(16'hF025, 16'h7000);
    send(16'h8000, 16'h7001);
    send(16'hD000, 16'h7002);
    send(16'h4800, 16'h7003);
    repeat (3) tick();

    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      IR_in     = 16'($urandom);
      npc_in    = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 63) != 0);
      tick();
    end

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    @(negedge clock);
    check("drained_out_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
